wb_macro_hub: RTL
=================

# wb_macro_hub

Parametrised successor to the single-macro user-area wrapper. It shares one Caravel Wishbone slave port, the 38-bit user IO bank and the 3-bit user IRQ among up to N_MACROS independently hardened macros. It also adds a registered bus bridge with timeout, break-before-make IO ownership switching, and sticky, maskable per-macro interrupts. It sits directly under user_project_wrapper, between the Caravel harness and the macros.

## Interface
- N_MACROS, 4, number of attached macros (1..15)
- IO_W, 38, user IO pad count
- TIMEOUT, 255, cycles a forwarded access may wait for a macro ack (1..255)

- wb_clk_i  in  1  single clock
- wb_rst_n_i  in  1  reset, asynchronous, active-low
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone slave strobe/cycle/write
- wbs_sel_i  in  4  byte selects
- wbs_adr_i, wbs_dat_i  in  32 each  address, write data
- wbs_ack_o  out  1  ack
- wbs_dat_o  out  32  read data
- m_stb_o  out  N_MACROS  per-macro strobe; cyc/we/sel/adr/dat are fanned out registered
- m_cyc_o, m_we_o  out  1 each  shared registered cyc/we
- m_sel_o  out  4  registered sel
- m_adr_o, m_dat_o  out  32 each  registered address/data
- m_ack_i  in  N_MACROS  per-macro ack
- m_dat_i  in  32*N_MACROS  per-macro read data, macro k at [32k+31:32k]
- m_io_out_i, m_io_oeb_i  in  IO_W*N_MACROS  per-macro pad drive
- io_out_o, io_oeb_o  out  IO_W each  to pads
- m_active_o  out  N_MACROS  one-hot IO owner indication
- m_irq_i  in  3*N_MACROS  per-macro IRQ lines
- user_irq_o  out  3  to harness

## Operation
- Decode uses wbs_adr_i[19:16]. Target 0 is hub registers at [3:2]. Target k (1..N_MACROS) is macro k-1. Targets above N_MACROS get a local ack with data 0 and set ERR.
- Hub registers:
  - 0x00 SEL[4:0]: bit4 = enable, [3:0] = owner index.
  - 0x04 IRQ_MASK[N-1:0].
  - 0x08 IRQ_STAT[N-1:0]: sticky, write-1-to-clear.
  - 0x0C ERR[0]: timeout/decode error, write-1-to-clear.
  - Reading 0x0C also returns the last timed-out target index in [11:8].
- The bus FSM has four states: IDLE, LOCAL, FWD, DONE.
  - IDLE: on stb&cyc, go to LOCAL for target 0 or a bad target, otherwise latch the request and go to FWD.
  - LOCAL: perform the read/write, assert wbs_ack_o, go to DONE.
  - FWD: hold m_stb_o[k] and m_cyc_o high. On m_ack_i[k], capture m_dat_i, assert wbs_ack_o and go to DONE.
  - FWD timeout (only with HUB_TIMEOUT_EN): when the counter reaches TIMEOUT, ack with 0xDEAD_BEEF, set ERR, record the index and go to DONE.
  - DONE: deassert everything and return to IDLE when stb drops, so ack is a single-cycle pulse.
- IO switch: a write to SEL that changes the owner forces io_oeb_o to all-1 and io_out_o to 0 for 2 cycles, then selects the new owner. A write with the same value causes no gap. With enable=0 or an index ≥ N_MACROS, all pads are inputs (oeb=1) and m_active_o = 0.
- IRQ handling:
  - Each macro's IRQ lines are OR-reduced and synchronised through 2 flops.
  - A rising edge sets IRQ_STAT[k]. If set and clear happen in the same cycle, set wins.
  - user_irq_o[0] = |(IRQ_STAT & IRQ_MASK).
  - user_irq_o[1] = ERR.
  - user_irq_o[2] = synchronised m_irq_i[2] of the current owner (0 if none).
- Reset mid-transaction: all outputs return to reset values immediately; a pending forwarded access is dropped without an ack.

## Timing
- Reset values:
  - wbs_ack_o=0, wbs_dat_o=0.
  - m_stb_o=0, m_cyc_o=0, m_we_o=0, m_sel_o=0, m_adr_o=0, m_dat_o=0.
  - io_out_o=0, io_oeb_o=all-1, m_active_o=0, user_irq_o=0.
  - SEL=0, IRQ_MASK=0, IRQ_STAT=0, ERR=0.
- Local access: stb sampled at edge T, ack high during cycle T+2.
- Forwarded access: m_stb_o is high from T+1. If the macro acks at edge A, wbs_ack_o is high during cycle A+1. Total latency is macro latency + 2.
- The timeout counter starts at m_stb_o assertion. The timeout ack is issued TIMEOUT+1 cycles after T+1.
- IRQ: a macro edge reaches user_irq_o[0] 3 cycles later.
- IO mux output is registered, 1 cycle after the SEL update plus any switch gap.

## Configuration
- HUB_TIMEOUT_EN defined: watchdog counter, 0xDEAD_BEEF timeout ack and ERR-on-timeout are compiled in.
- HUB_TIMEOUT_EN undefined: FWD waits indefinitely for m_ack_i. ERR is set only by bad-target decode. The TIMEOUT parameter is ignored.

## Test plan
- Reset then read 0x3000_0000 -> ack at T+2 with data 0; io_oeb_o=all-1, user_irq_o=0.
- Write SEL=0x11 while macro 1 drives io_out=0x15 → exactly 2 gap cycles with oeb=all-1, then io_out_o=0x15, m_active_o=0b0010.
- Read target 2 with a macro acking 3 cycles after stb, data 0xA5A5_0001 -> wbs_dat_o=0xA5A5_0001, single-cycle ack.
- HUB_TIMEOUT_EN, TIMEOUT=8, macro never acks -> ack with 0xDEAD_BEEF after 9 stb cycles; ERR=1; user_irq_o[1]=1; 0x0C reads 0x0000_0101 for target 1.
- IRQ_MASK=0b0100, pulse macro 2 IRQ for 1 cycle → user_irq_o[0]=1 three cycles later; W1C 0x08=0b0100 → user_irq_o[0]=0; a simultaneous new edge keeps the bit set.
- Assert wb_rst_n_i during FWD → no ack, m_stb_o=0 immediately, and the next access after reset proceeds normally.

Source files
------------

// File: rtl/wb_macro_hub.sv
// wb_macro_hub: shares one Wishbone slave, the user IO bank and user IRQs among N_MACROS macros.
// Define HUB_TIMEOUT_EN to compile in the forwarded-access watchdog (0xDEAD_BEEF ack, ERR on timeout).
module wb_macro_hub #(
    parameter int N_MACROS = 4,
    parameter int IO_W     = 38,
    parameter int TIMEOUT  = 255
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_n_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_we_i,
    input  logic [3:0]               wbs_sel_i,
    input  logic [31:0]              wbs_adr_i,
    input  logic [31:0]              wbs_dat_i,
    output logic                     wbs_ack_o,
    output logic [31:0]              wbs_dat_o,
    output logic [N_MACROS-1:0]      m_stb_o,
    output logic                     m_cyc_o,
    output logic                     m_we_o,
    output logic [3:0]               m_sel_o,
    output logic [31:0]              m_adr_o,
    output logic [31:0]              m_dat_o,
    input  logic [N_MACROS-1:0]      m_ack_i,
    input  logic [32*N_MACROS-1:0]   m_dat_i,
    input  logic [IO_W*N_MACROS-1:0] m_io_out_i,
    input  logic [IO_W*N_MACROS-1:0] m_io_oeb_i,
    output logic [IO_W-1:0]          io_out_o,
    output logic [IO_W-1:0]          io_oeb_o,
    output logic [N_MACROS-1:0]      m_active_o,
    input  logic [3*N_MACROS-1:0]    m_irq_i,
    output logic [2:0]               user_irq_o
);
    localparam logic [3:0] NM = 4'(N_MACROS);

    typedef enum logic [1:0] {IDLE, LOCAL, FWD, DONE} state_t;

    state_t              state;
    logic [3:0]          tgt;
    logic [4:0]          sel;
    logic [N_MACROS-1:0] irq_mask;
    logic [N_MACROS-1:0] irq_stat;
    logic                err;
    logic [3:0]          last_idx;
`ifdef HUB_TIMEOUT_EN
    logic [7:0]          cnt;
`else
    logic                unused_timeout;
    assign unused_timeout = |TIMEOUT;
`endif

    logic [3:0]          req_tgt;
    logic                req_local;
    logic                tgt_hub;
    logic                tgt_bad;
    logic                hub_wr;
    logic [1:0]          ra;
    logic [31:0]         hub_rd;
    logic                fwd_ack;
    logic [31:0]         fwd_dat;
    logic [N_MACROS-1:0] stat_clr;
    logic                sel_chg;

    always_comb begin
        req_tgt   = wbs_adr_i[19:16];
        req_local = req_tgt == 4'd0 || req_tgt > NM;
        tgt_hub   = tgt == 4'd0;
        tgt_bad   = tgt > NM;
        hub_wr    = state == LOCAL && tgt_hub && m_we_o;
        ra        = m_adr_o[3:2];
        hub_rd    = ra == 2'd0 ? {27'd0, sel} :
                    ra == 2'd1 ? 32'(irq_mask) :
                    ra == 2'd2 ? 32'(irq_stat) :
                                 {20'd0, last_idx, 7'd0, err};
        stat_clr  = (hub_wr && ra == 2'd2) ? m_dat_o[N_MACROS-1:0] : '0;
        sel_chg   = hub_wr && ra == 2'd0 && m_dat_o[4:0] != sel;
        fwd_ack   = |(m_ack_i & m_stb_o);
        fwd_dat   = '0;
        for (int k = 0; k < N_MACROS; k++)
            fwd_dat = fwd_dat | (m_stb_o[k] ? m_dat_i[32*k +: 32] : 32'd0);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state     <= IDLE;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            m_stb_o   <= '0;
            m_cyc_o   <= 1'b0;
            m_we_o    <= 1'b0;
            m_sel_o   <= '0;
            m_adr_o   <= '0;
            m_dat_o   <= '0;
            tgt       <= '0;
            sel       <= '0;
            irq_mask  <= '0;
            err       <= 1'b0;
            last_idx  <= '0;
`ifdef HUB_TIMEOUT_EN
            cnt       <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (wbs_stb_i && wbs_cyc_i) begin
                    m_adr_o <= wbs_adr_i;
                    m_dat_o <= wbs_dat_i;
                    m_we_o  <= wbs_we_i;
                    m_sel_o <= wbs_sel_i;
                    tgt     <= req_tgt;
`ifdef HUB_TIMEOUT_EN
                    cnt     <= '0;
`endif
                    if (req_local) begin
                        state <= LOCAL;
                    end else begin
                        m_stb_o <= N_MACROS'(1) << (req_tgt - 4'd1);
                        m_cyc_o <= 1'b1;
                        state   <= FWD;
                    end
                end
                LOCAL: begin
                    wbs_ack_o <= 1'b1;
                    wbs_dat_o <= (tgt_hub && !m_we_o) ? hub_rd : 32'd0;
                    if (tgt_bad) err <= 1'b1;
                    if (hub_wr && ra == 2'd0) sel <= m_dat_o[4:0];
                    if (hub_wr && ra == 2'd1) irq_mask <= m_dat_o[N_MACROS-1:0];
                    if (hub_wr && ra == 2'd3 && m_dat_o[0]) err <= 1'b0;
                    state <= DONE;
                end
                FWD: if (fwd_ack) begin
                    wbs_ack_o <= 1'b1;
                    wbs_dat_o <= fwd_dat;
                    m_stb_o   <= '0;
                    m_cyc_o   <= 1'b0;
                    state     <= DONE;
`ifdef HUB_TIMEOUT_EN
                end else if (cnt == 8'(TIMEOUT)) begin
                    wbs_ack_o <= 1'b1;
                    wbs_dat_o <= 32'hDEAD_BEEF;
                    m_stb_o   <= '0;
                    m_cyc_o   <= 1'b0;
                    err       <= 1'b1;
                    last_idx  <= tgt;
                    state     <= DONE;
                end else begin
                    cnt <= cnt + 8'd1;
`endif
                end
                DONE: begin
                    wbs_ack_o <= 1'b0;
                    if (!wbs_stb_i) state <= IDLE;
                end
            endcase
        end
    end

    logic [1:0]          gap;
    logic [N_MACROS-1:0] nxt_act;
    logic [IO_W-1:0]     mux_out;
    logic [IO_W-1:0]     mux_oeb;

    always_comb begin
        nxt_act = '0;
        mux_out = '0;
        mux_oeb = '1;
        for (int k = 0; k < N_MACROS; k++) begin
            nxt_act[k] = sel[4] && sel[3:0] == 4'(k);
            mux_out    = mux_out | (nxt_act[k] ? m_io_out_i[IO_W*k +: IO_W] : '0);
            mux_oeb    = mux_oeb & (nxt_act[k] ? m_io_oeb_i[IO_W*k +: IO_W] : '1);
        end
    end

    // Owner changes tri-state the pads for two cycles before the new owner drives them.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            gap        <= '0;
            io_out_o   <= '0;
            io_oeb_o   <= '1;
            m_active_o <= '0;
        end else begin
            gap        <= sel_chg ? 2'd2 : (gap != 2'd0 ? gap - 2'd1 : 2'd0);
            io_out_o   <= gap != 2'd0 ? '0 : mux_out;
            io_oeb_o   <= gap != 2'd0 ? '1 : mux_oeb;
            m_active_o <= gap != 2'd0 ? '0 : nxt_act;
        end
    end

    logic [N_MACROS-1:0] irq_any, irq_hi;
    logic [N_MACROS-1:0] s1, s2, s3, h1, h2;

    always_comb begin
        irq_any = '0;
        irq_hi  = '0;
        for (int k = 0; k < N_MACROS; k++) begin
            irq_any[k] = |m_irq_i[3*k +: 3];
            irq_hi[k]  = m_irq_i[3*k+2];
        end
    end

    // A new edge in the same cycle as a W1C keeps the status bit set.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            s1       <= '0;
            s2       <= '0;
            s3       <= '0;
            h1       <= '0;
            h2       <= '0;
            irq_stat <= '0;
        end else begin
            s1       <= irq_any;
            s2       <= s1;
            s3       <= s2;
            h1       <= irq_hi;
            h2       <= h1;
            irq_stat <= (irq_stat & ~stat_clr) | (s2 & ~s3);
        end
    end

    assign user_irq_o = {|(h2 & m_active_o), err, |(irq_stat & irq_mask)};
endmodule
